dpad_conditioner: RTL and testbench
===================================

// Module: dpad_conditioner
// PURPOSE
//  Upstream input stage for the frog movement logic. Takes the four raw, asynchronous
//  d-pad buttons and synchronises and debounces each one. Produces clean held levels,
//  plus single-cycle press pulses with optional auto-repeat. The pulse bus is what
//  frog consumes as dpad_input, with bit order {right, up, down, left}.
// PARAMETERS
//  N_BTN            4        number of buttons; bit i of every bus is the same button
//  DEBOUNCE_CYCLES  251000   consecutive stable samples needed to accept a change (~10 ms @ 25.1 MHz)
//  REPEAT_CYCLES    0        hold time between auto-repeat pulses; 0 = auto-repeat disabled
//  ACTIVE_LOW       0        1 = raw button reads 0 when pressed (inverted after the synchroniser)
// PORTS
//  clk         in   1      pixel clock (25.1 MHz)
//  reset       in   1      asynchronous, active-high reset
//  btn_raw     in   N_BTN  raw pad inputs {right, up, down, left}
//  btn_level   out  N_BTN  debounced pressed state, 1 = held
//  btn_pulse   out  N_BTN  1-cycle pulse per accepted press and per auto-repeat
//  move_onehot out  N_BTN  btn_pulse reduced to at most one bit set (priority below)
// BEHAVIOUR
//  Reset state
//   - All outputs 0, synchroniser flops 0 (post-polarity), counters 0, every FSM in RELEASED.
//   - Reset asserted mid-count or while held discards all progress.
//   - After release, a held button is re-accepted only after the full debounce window.
//  Synchroniser
//   - Two flops per bit; polarity applied after the second flop, giving s[i].
//  Debounce (per bit, counter width $clog2(DEBOUNCE_CYCLES+1))
//   - Each cycle s[i] equals btn_level[i]: counter clears to 0.
//   - Each cycle s[i] differs from btn_level[i]: counter increments.
//   - When it would reach DEBOUNCE_CYCLES: btn_level[i] toggles and the counter clears.
//   - Any single-cycle glitch shorter than DEBOUNCE_CYCLES restarts the count and produces no output.
//   - Latency from raw edge to btn_level edge = 2 + DEBOUNCE_CYCLES clocks.
//  Per-button FSM
//   - RELEASED -> PRESSED on level 0->1: btn_pulse[i]=1 in the same cycle btn_level[i] rises; rep_cnt cleared.
//   - PRESSED -> PRESSED (REPEAT_CYCLES>0):
//     - rep_cnt increments each held cycle.
//     - When rep_cnt reaches REPEAT_CYCLES-1: btn_pulse[i]=1 for one cycle and rep_cnt clears.
//     - Repeat period is exactly REPEAT_CYCLES.
//   - PRESSED -> RELEASED on level 1->0: no pulse; an in-flight repeat count is dropped.
//   - btn_pulse[i] is never high two consecutive cycles unless REPEAT_CYCLES==1.
//  move_onehot
//   - Combinational from the registered btn_pulse.
//   - Priority MSB first: right > up > down > left.
//   - Lower-priority simultaneous pulses are dropped, not queued.
//  Width / overflow
//   - Counters saturate-free by construction: they clear on accept/repeat.
//   - There is no wrap path.
// TESTING (sim with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=0 unless stated)
//  1. Clean press on up, raw held 20 cycles.
//     -> btn_level[2] rises 6 clocks after the raw edge.
//     -> btn_pulse=4'b0100 for exactly 1 cycle.
//  2. Bounce on left: 1,0,1,0 for 1 cycle each, then steady 1.
//     -> exactly one pulse, 6 clocks after the last edge.
//     -> btn_level clean throughout.
//  3. Right and down pressed on the same edge.
//     -> btn_pulse=4'b1010 and move_onehot=4'b1000 in the same cycle.
//  4. REPEAT_CYCLES=8, hold down 40 cycles after acceptance.
//     -> pulses at acceptance +8, +16, +24, +32.
//     -> none after release.
//  5. Reset asserted 2 cycles into a debounce count, released while the raw button is still held.
//     -> outputs 0 asynchronously.
//     -> pulse appears 6 clocks after reset deassertion.
//  6. ACTIVE_LOW=1, raw idle high.
//     -> no pulse after reset.
//     -> driving raw low produces a pulse after 6 clocks.

Source files
------------

// File: rtl/dpad_conditioner.sv
// D-pad conditioner: 2-flop sync, per-bit debounce, press/repeat pulses.
// Ports: clk, reset (async high), btn_raw in; btn_level, btn_pulse, move_onehot out.
module dpad_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 251000,
  parameter int REPEAT_CYCLES   = 0,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] move_onehot
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RP_LAST =
    RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  // Sync flops reset to the idle raw value so s[] starts at 0.
  localparam logic [N_BTN-1:0] POL = {N_BTN{ACTIVE_LOW}};

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } state_e;

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] s;

  logic [CW-1:0]    db_cnt_q [N_BTN];
  logic [CW-1:0]    db_cnt_d [N_BTN];
  logic [N_BTN-1:0] level_q;
  logic [N_BTN-1:0] level_d;

  state_e           state_q   [N_BTN];
  state_e           state_d   [N_BTN];
  logic [RW-1:0]    rep_cnt_q [N_BTN];
  logic [RW-1:0]    rep_cnt_d [N_BTN];
  logic [N_BTN-1:0] pulse_q;
  logic [N_BTN-1:0] pulse_d;

  assign s = sync2_q ^ POL;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= POL;
      sync2_q <= POL;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive samples that disagree with the held level;
  // the DEBOUNCE_CYCLES-th such sample flips the level.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N_BTN; i++) begin
      db_cnt_d[i] = '0;
      if (s[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i] = s[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // The FSM looks at level_d so the press pulse lands
  // in the same cycle the registered level rises.
  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i]   = state_q[i];
      rep_cnt_d[i] = rep_cnt_q[i];
      unique case (state_q[i])
        RELEASED: begin
          if (level_d[i]) begin
            state_d[i]   = PRESSED;
            pulse_d[i]   = 1'b1;
            rep_cnt_d[i] = '0;
          end
        end
        PRESSED: begin
          if (!level_d[i]) begin
            state_d[i]   = RELEASED;
            rep_cnt_d[i] = '0;
          end else if (REPEAT_CYCLES > 0) begin
            if (rep_cnt_q[i] == RP_LAST) begin
              pulse_d[i]   = 1'b1;
              rep_cnt_d[i] = '0;
            end else begin
              rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      pulse_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt_q[i]  <= '0;
        rep_cnt_q[i] <= '0;
        state_q[i]   <= RELEASED;
      end
    end else begin
      level_q <= level_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt_q[i]  <= db_cnt_d[i];
        rep_cnt_q[i] <= rep_cnt_d[i];
        state_q[i]   <= state_d[i];
      end
    end
  end

  // Highest index wins; lower simultaneous pulses are dropped.
  always_comb begin
    move_onehot = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (pulse_q[i]) begin
        move_onehot    = '0;
        move_onehot[i] = 1'b1;
      end
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule

// File: tb/tb_dpad_conditioner.sv
// Bench for dpad_conditioner: three instances (plain, repeat=8, active-low)
// checked against a window-based reference model plus directed sequences.
module tb_dpad_conditioner;

  localparam int ND = 3;
  localparam int NB = 4;
  localparam int DB = 4;

  logic       clk;
  logic       reset;
  logic [3:0] raw   [ND];
  logic [3:0] lvl_o [ND];
  logic [3:0] pul_o [ND];
  logic [3:0] oh_o  [ND];

  int n_checks = 0;
  int n_fail   = 0;

  dpad_conditioner #(
    .N_BTN(4), .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES(0), .ACTIVE_LOW(1'b0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .btn_raw(raw[0]),
    .btn_level(lvl_o[0]), .btn_pulse(pul_o[0]),
    .move_onehot(oh_o[0])
  );

  dpad_conditioner #(
    .N_BTN(4), .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES(8), .ACTIVE_LOW(1'b0)
  ) u_dut1 (
    .clk(clk), .reset(reset), .btn_raw(raw[1]),
    .btn_level(lvl_o[1]), .btn_pulse(pul_o[1]),
    .move_onehot(oh_o[1])
  );

  dpad_conditioner #(
    .N_BTN(4), .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES(0), .ACTIVE_LOW(1'b1)
  ) u_dut2 (
    .clk(clk), .reset(reset), .btn_raw(raw[2]),
    .btn_level(lvl_o[2]), .btn_pulse(pul_o[2]),
    .move_onehot(oh_o[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rep_of(int d);
    return (d == 1) ? 8 : 0;
  endfunction

  function automatic bit al_of(int d);
    return (d == 2);
  endfunction

  // Reference model state (raw-domain sync stages, window of last DB s samples)
  bit m_s1  [ND][NB];
  bit m_s2  [ND][NB];
  bit m_win [ND][NB][DB];
  bit m_lvl [ND][NB];
  bit m_pul [ND][NB];
  int m_age [ND][NB];

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      for (int b = 0; b < NB; b++) begin
        m_s1[d][b]  = al_of(d);
        m_s2[d][b]  = al_of(d);
        m_lvl[d][b] = 1'b0;
        m_pul[d][b] = 1'b0;
        m_age[d][b] = 0;
        for (int k = 0; k < DB; k++) m_win[d][b][k] = 1'b0;
      end
    end
  endtask

  // Level flips once the last DB samples all disagree with it; repeats
  // fire every rep_of(d) cycles of hold after acceptance.
  task automatic model_step();
    bit s, all_diff, rose;
    for (int d = 0; d < ND; d++) begin
      for (int b = 0; b < NB; b++) begin
        s = m_s2[d][b] ^ al_of(d);
        for (int k = DB - 1; k > 0; k--) m_win[d][b][k] = m_win[d][b][k-1];
        m_win[d][b][0] = s;
        all_diff = 1'b1;
        for (int k = 0; k < DB; k++)
          if (m_win[d][b][k] == m_lvl[d][b]) all_diff = 1'b0;
        rose = 1'b0;
        if (all_diff) begin
          m_lvl[d][b] = ~m_lvl[d][b];
          rose = m_lvl[d][b];
          m_age[d][b] = 0;
        end else if (m_lvl[d][b]) begin
          m_age[d][b]++;
        end
        m_pul[d][b] = rose ||
          (m_lvl[d][b] && rep_of(d) > 0 && m_age[d][b] > 0 &&
           (m_age[d][b] % rep_of(d)) == 0);
        m_s2[d][b] = m_s1[d][b];
        m_s1[d][b] = raw[d][b];
      end
    end
  endtask

  task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [3:0] el, ep, eo;
    for (int d = 0; d < ND; d++) begin
      for (int b = 0; b < NB; b++) begin
        el[b] = m_lvl[d][b];
        ep[b] = m_pul[d][b];
      end
      eo = '0;
      for (int b = NB - 1; b >= 0; b--)
        if (ep[b] && eo == '0) eo[b] = 1'b1;
      chk($sformatf("model_level_dut%0d", d), lvl_o[d], el);
      chk($sformatf("model_pulse_dut%0d", d), pul_o[d], ep);
      chk($sformatf("model_onehot_dut%0d", d), oh_o[d], eo);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    logic [3:0] press;
    logic [3:0] pulse;
    logic [3:0] onehot;
  } vec_t;

  vec_t tbl [6];
  int   pcount;

  initial begin
    tbl[0] = '{4'b0100, 4'b0100, 4'b0100};
    tbl[1] = '{4'b1010, 4'b1010, 4'b1000};
    tbl[2] = '{4'b0011, 4'b0011, 4'b0010};
    tbl[3] = '{4'b1111, 4'b1111, 4'b1000};
    tbl[4] = '{4'b0001, 4'b0001, 4'b0001};
    tbl[5] = '{4'b0110, 4'b0110, 4'b0100};

    reset  = 1'b1;
    raw[0] = 4'b0000;
    raw[1] = 4'b0000;
    raw[2] = 4'b1111;
    model_reset();
    repeat (3) tick();
    reset = 1'b0;

    for (int d = 0; d < ND; d++) begin
      chk("reset_level", lvl_o[d], 4'b0000);
      chk("reset_pulse", pul_o[d], 4'b0000);
      chk("reset_onehot", oh_o[d], 4'b0000);
    end

    // Active-low instance: idle-high raw gives nothing, then press right
    pcount = 0;
    repeat (10) begin
      tick();
      if (pul_o[2] != 4'b0000) pcount++;
    end
    chk("al_idle_pulses", 4'(pcount), 4'd0);
    raw[2] = 4'b0111;
    repeat (5) tick();
    chk("al_pre_pulse", pul_o[2], 4'b0000);
    tick();
    chk("al_pulse", pul_o[2], 4'b1000);
    chk("al_onehot", oh_o[2], 4'b1000);
    raw[2] = 4'b1111;
    repeat (8) tick();

    // Clean press on up held 20 cycles
    raw[0] = 4'b0100;
    repeat (5) tick();
    chk("up_level_early", lvl_o[0], 4'b0000);
    tick();
    chk("up_level", lvl_o[0], 4'b0100);
    chk("up_pulse", pul_o[0], 4'b0100);
    pcount = 0;
    repeat (14) begin
      tick();
      if (pul_o[0] != 4'b0000) pcount++;
    end
    chk("up_single_pulse", 4'(pcount), 4'd0);
    raw[0] = 4'b0000;
    repeat (8) tick();

    // Bounce on left then steady
    raw[0] = 4'b0001; tick();
    raw[0] = 4'b0000; tick();
    raw[0] = 4'b0001; tick();
    raw[0] = 4'b0000; tick();
    raw[0] = 4'b0001;
    pcount = 0;
    repeat (5) begin
      tick();
      if (pul_o[0] != 4'b0000) pcount++;
      chk("bounce_level_low", lvl_o[0], 4'b0000);
    end
    tick();
    chk("bounce_pulse", pul_o[0], 4'b0001);
    pcount++;
    repeat (10) begin
      tick();
      if (pul_o[0] != 4'b0000) pcount++;
    end
    chk("bounce_one_pulse", 4'(pcount), 4'd1);
    raw[0] = 4'b0000;
    repeat (8) tick();

    // Simultaneous press table
    foreach (tbl[i]) begin
      raw[0] = tbl[i].press;
      repeat (5) tick();
      chk($sformatf("tbl%0d_pre", i), pul_o[0], 4'b0000);
      tick();
      chk($sformatf("tbl%0d_pulse", i), pul_o[0], tbl[i].pulse);
      chk($sformatf("tbl%0d_onehot", i), oh_o[0], tbl[i].onehot);
      tick();
      chk($sformatf("tbl%0d_post", i), pul_o[0], 4'b0000);
      raw[0] = 4'b0000;
      repeat (8) tick();
    end

    // Auto-repeat on down, raw released 34 cycles after acceptance
    raw[1] = 4'b0010;
    repeat (6) tick();
    chk("rep_accept", pul_o[1], 4'b0010);
    for (int k = 1; k <= 60; k++) begin
      tick();
      chk($sformatf("rep_pulse_k%0d", k), pul_o[1],
          ((k % 8) == 0 && k <= 32) ? 4'b0010 : 4'b0000);
      chk($sformatf("rep_level_k%0d", k), lvl_o[1],
          (k < 40) ? 4'b0010 : 4'b0000);
      if (k == 34) raw[1] = 4'b0000;
    end

    // Reset mid-count while held
    raw[0] = 4'b0001;
    repeat (6) tick();
    chk("rst_pre_level", lvl_o[0], 4'b0001);
    raw[0] = 4'b0101;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    chk("rst_async_level", lvl_o[0], 4'b0000);
    chk("rst_async_pulse", pul_o[0], 4'b0000);
    model_reset();
    tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("rst_pre_pulse", pul_o[0], 4'b0000);
    tick();
    chk("rst_pulse", pul_o[0], 4'b0101);
    chk("rst_level", lvl_o[0], 4'b0101);
    chk("rst_onehot", oh_o[0], 4'b0100);
    raw[0] = 4'b0000;
    repeat (8) tick();

    // Random bouncing against the model, with one reset in the middle
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) reset = 1'b1;
      if (c == 703) reset = 1'b0;
      for (int d = 0; d < ND; d++)
        for (int b = 0; b < NB; b++)
          if ($urandom_range(0, (d == 1) ? 15 : 7) == 0)
            raw[d][b] = ~raw[d][b];
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
